// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with packet-hold locking.
// An agent may win up to its weight in consecutive completed transactions
// before priority moves on. While hold_i is asserted, the current grantee
// stays locked until it completes a transaction.
module weighted_rr_arbiter #(
    parameter int AGENTS_NUM   = 4,
    parameter int WEIGHT_WIDTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AGENTS_NUM-1:0]              requests_i,
    input  logic [AGENTS_NUM*WEIGHT_WIDTH-1:0] weights_i,
    input  logic                               hold_i,
    output logic [AGENTS_NUM-1:0]              grants_o,
    output logic                               locked_o
);

    localparam int AGENTS_PTR_SIZE = $clog2(AGENTS_NUM);

    typedef logic [AGENTS_PTR_SIZE-1:0] ptr_t;
    typedef logic [WEIGHT_WIDTH-1:0]    weight_t;
    typedef enum logic {MODE_UNLOCKED, MODE_LOCKED} mode_e;

    ptr_t    ptr_q, ptr_d;
    weight_t credit_q, credit_d;
    mode_e   mode_q, mode_d;
    ptr_t    lockAgent_q, lockAgent_d;

    ptr_t    grantIdx;
    logic    grantValid;
    weight_t creditUsed;
    ptr_t    successor;

    // A programmed weight of zero is treated as one so every agent gets a turn.
    function automatic weight_t effWeight(input ptr_t idx,
                                          input logic [AGENTS_NUM*WEIGHT_WIDTH-1:0] w);
        weight_t result;
        result = '0;
        for (int i = 0; i < AGENTS_NUM; i++) begin
            if (ptr_t'(i) == idx) begin
                result = w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        if (result == '0) begin
            result = weight_t'(1);
        end
        return result;
    endfunction

    // Cyclic successor; wraps explicitly so non-power-of-two agent counts work.
    function automatic ptr_t nextAgent(input ptr_t idx);
        return (idx == ptr_t'(AGENTS_NUM - 1)) ? '0 : idx + ptr_t'(1);
    endfunction

    // Pick the winner: the lock owner while locked, otherwise the first
    // requester in cyclic order starting at the priority pointer.
    always_comb begin
        ptr_t cand;
        grantValid = 1'b0;
        grantIdx   = lockAgent_q;
        cand       = ptr_q;
        if (mode_q == MODE_LOCKED) begin
            grantValid = requests_i[lockAgent_q];
            grantIdx   = lockAgent_q;
        end else begin
            for (int k = 0; k < AGENTS_NUM; k++) begin
                if (!grantValid && requests_i[cand]) begin
                    grantValid = 1'b1;
                    grantIdx   = cand;
                end
                cand = nextAgent(cand);
            end
        end
    end

    // Decode the winner index into a one-hot grant vector.
    always_comb begin
        grants_o = '0;
        if (grantValid) begin
            grants_o[grantIdx] = 1'b1;
        end
    end

    // Next-state: a held grant locks the winner; a completed grant spends one
    // credit, reloading from the weights when the pointer's credit runs out.
    always_comb begin
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        mode_d      = mode_q;
        lockAgent_d = lockAgent_q;
        successor   = nextAgent(grantIdx);
        creditUsed  = ((grantIdx == ptr_q) && (credit_q != '0)) ? credit_q
                                                               : effWeight(grantIdx, weights_i);
        if (grantValid) begin
            if (hold_i) begin
                mode_d      = MODE_LOCKED;
                lockAgent_d = grantIdx;
            end else begin
                mode_d = MODE_UNLOCKED;
                if (creditUsed > weight_t'(1)) begin
                    ptr_d    = grantIdx;
                    credit_d = creditUsed - weight_t'(1);
                end else begin
                    ptr_d    = successor;
                    credit_d = effWeight(successor, weights_i);
                end
            end
        end
    end

    // State registers; reset drops any lock immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            credit_q    <= '0;
            mode_q      <= MODE_UNLOCKED;
            lockAgent_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            mode_q      <= mode_d;
            lockAgent_q <= lockAgent_d;
        end
    end

    assign locked_o = (mode_q == MODE_LOCKED);

endmodule
